// File: rtl/snn_syn_pkg.sv
// Shared constants and types for the STDP synapse layer.
package snn_syn_pkg;

    localparam int unsigned N_SYN    = 25;
    localparam int unsigned W_BITS   = 4;
    localparam int unsigned W_INIT   = 8;
    localparam int unsigned W_MID    = 8;
    localparam int unsigned WIN      = 15;
    localparam int unsigned T_BITS   = 4;
    localparam int unsigned IDX_BITS = $clog2(N_SYN);
    localparam int unsigned W_MAX    = (1 << W_BITS) - 1;

    typedef logic [W_BITS-1:0] weight_t;

    typedef enum logic {
        StIdle,
        StScan
    } scan_state_e;

endpackage

// File: rtl/syn_trace.sv
// Loadable saturating down-counter: load sets it to LoadVal, otherwise it counts down to 0.
module syn_trace #(
    parameter int unsigned Width   = 4,
    parameter int unsigned LoadVal = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    // Next count: reload on load, otherwise decrement and stick at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = Width'(LoadVal);
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/stdp_synapse_array.sv
// 25-input synapse layer with pair-based STDP: sequential potentiation scan on post,
// parallel depression on pre-spikes that arrive inside the post window.
module stdp_synapse_array
    import snn_syn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     learn_i,
    input  logic [N_SYN-1:0]         pre_spike_i,
    input  logic                     post_i,
    output logic [N_SYN-1:0]         weight_up_o,
    output logic [N_SYN-1:0]         weight_down_o,
    output logic [N_SYN*W_BITS-1:0]  weights_o,
    output logic                     scan_busy_o
);

    logic [T_BITS-1:0]   pre_trace [N_SYN];
    logic [T_BITS-1:0]   post_trace;
    logic [N_SYN-1:0]    pre_live;
    logic                post_live;
    logic                post_q;
    logic                post_rise;

    scan_state_e         state_d, state_q;
    logic [IDX_BITS-1:0] idx_d, idx_q;
    logic [N_SYN-1:0]    pend_d, pend_q;
    logic [N_SYN-1:0]    inc_vec;
    logic [N_SYN-1:0]    dec_vec;

    weight_t             w_d [N_SYN];
    weight_t             w_q [N_SYN];
    logic [N_SYN-1:0]    up_d, up_q;
    logic [N_SYN-1:0]    down_d, down_q;

    // A post level held for several cycles is one event.
    assign post_rise = post_i & ~post_q;
    assign post_live = (post_trace != '0);

    for (genvar g = 0; g < N_SYN; g++) begin : g_pre_trace
        syn_trace #(
            .Width   (T_BITS),
            .LoadVal (WIN)
        ) u_pre_trace (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (pre_spike_i[g]),
            .count_o (pre_trace[g])
        );
        assign pre_live[g] = (pre_trace[g] != '0);
    end

    syn_trace #(
        .Width   (T_BITS),
        .LoadVal (WIN)
    ) u_post_trace (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (post_rise),
        .count_o (post_trace)
    );

    // Scan FSM: snapshot live pre traces on post rise, then walk one synapse per cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        inc_vec = '0;
        unique case (state_q)
            StIdle: begin
                if (post_rise && learn_i) begin
                    state_d = StScan;
                    idx_d   = '0;
                    // Old trace value, so a pre-spike coinciding with post never self-pairs.
                    pend_d  = pre_live;
                end
            end
            StScan: begin
                if (!learn_i) begin
                    state_d = StIdle;
                end else begin
                    for (int i = 0; i < N_SYN; i++) begin
                        inc_vec[i] = pend_q[i] && (idx_q == IDX_BITS'(i));
                    end
                    idx_d = idx_q + IDX_BITS'(1);
                    if (idx_q == IDX_BITS'(N_SYN - 1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Weight update: saturating inc/dec, simultaneous inc and dec cancel.
    always_comb begin
        for (int i = 0; i < N_SYN; i++) begin
            dec_vec[i] = learn_i && pre_spike_i[i] && post_live;
            w_d[i]     = w_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                if (w_q[i] != weight_t'(W_MAX)) begin
                    w_d[i] = w_q[i] + weight_t'(1);
                end
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (w_q[i] != '0) begin
                    w_d[i] = w_q[i] - weight_t'(1);
                end
            end
        end
    end

    // Drive decode from the weight held before this cycle's update.
    always_comb begin
        up_d   = '0;
        down_d = '0;
        for (int i = 0; i < N_SYN; i++) begin
            up_d[i]   = pre_spike_i[i] && (w_q[i] > weight_t'(W_MID));
            down_d[i] = pre_spike_i[i] && (w_q[i] < weight_t'(W_MID));
        end
    end

    // State, weights and drive registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pend_q  <= '0;
            post_q  <= 1'b0;
            up_q    <= '0;
            down_q  <= '0;
            for (int i = 0; i < N_SYN; i++) begin
                w_q[i] <= weight_t'(W_INIT);
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            post_q  <= post_i;
            up_q    <= up_d;
            down_q  <= down_d;
            for (int i = 0; i < N_SYN; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    // Flatten weights onto the output bus.
    always_comb begin
        weights_o = '0;
        for (int i = 0; i < N_SYN; i++) begin
            weights_o[i*W_BITS +: W_BITS] = w_q[i];
        end
    end

    assign weight_up_o   = up_q;
    assign weight_down_o = down_q;
    assign scan_busy_o   = (state_q == StScan);

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Self-checking bench for stdp_synapse_array against a timestamp-based STDP model.
module tb_stdp_synapse_array;

    localparam int N   = 25;
    localparam int WB  = 4;
    localparam int WIN = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              learn = 1'b0;
    logic [N-1:0]      pre = '0;
    logic              post = 1'b0;
    logic [N-1:0]      weight_up;
    logic [N-1:0]      weight_down;
    logic [N*WB-1:0]   weights;
    logic              scan_busy;

    int n_pass  = 0;
    int n_total = 0;

    stdp_synapse_array u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .learn_i       (learn),
        .pre_spike_i   (pre),
        .post_i        (post),
        .weight_up_o   (weight_up),
        .weight_down_o (weight_down),
        .weights_o     (weights),
        .scan_busy_o   (scan_busy)
    );

    always #5 clk = ~clk;

    // Model: traces expressed as "time since last event"; scan as a position in a list.
    int        cyc;
    int        pre_last [N];
    int        post_last;
    bit        post_prev;
    int        wm [N];
    bit        scanning;
    int        scan_pos;
    bit        pendm [N];
    logic [N-1:0] exp_up;
    logic [N-1:0] exp_down;

    function automatic logic [N*WB-1:0] model_weights();
        logic [N*WB-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*WB +: WB] = WB'(wm[i]);
        return v;
    endfunction

    task automatic model_reset();
        cyc = 0;
        post_last = -100;
        post_prev = 1'b0;
        scanning = 1'b0;
        scan_pos = 0;
        exp_up = '0;
        exp_down = '0;
        for (int i = 0; i < N; i++) begin
            pre_last[i] = -100;
            wm[i] = 8;
            pendm[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit post_act;
        bit rise;
        bit live [N];
        bit dep [N];
        bit inc [N];
        post_act = (cyc - post_last >= 1) && (cyc - post_last <= WIN);
        rise = post && !post_prev;
        for (int i = 0; i < N; i++) begin
            live[i] = (cyc - pre_last[i] >= 1) && (cyc - pre_last[i] <= WIN);
            exp_up[i] = pre[i] && (wm[i] > 8);
            exp_down[i] = pre[i] && (wm[i] < 8);
            dep[i] = learn && pre[i] && post_act;
            inc[i] = 1'b0;
        end
        if (scanning && learn && pendm[scan_pos]) inc[scan_pos] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (inc[i] && !dep[i]) wm[i] = (wm[i] == 15) ? 15 : wm[i] + 1;
            else if (dep[i] && !inc[i]) wm[i] = (wm[i] == 0) ? 0 : wm[i] - 1;
        end
        if (scanning) begin
            if (!learn) scanning = 1'b0;
            else begin
                scan_pos++;
                if (scan_pos == N) scanning = 1'b0;
            end
        end else if (rise && learn) begin
            scanning = 1'b1;
            scan_pos = 0;
            for (int i = 0; i < N; i++) pendm[i] = live[i];
        end
        for (int i = 0; i < N; i++) if (pre[i]) pre_last[i] = cyc;
        if (rise) post_last = cyc;
        post_prev = post;
        cyc++;
    endtask

    // One clock: drive on negedge, model on posedge, return 1 time unit after the edge.
    task automatic tick(input logic [N-1:0] p, input logic po, input logic l);
        @(negedge clk);
        pre = p;
        post = po;
        learn = l;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n, input logic l);
        for (int k = 0; k < n; k++) tick('0, 1'b0, l);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pre = '0;
        post = 1'b0;
        learn = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++;
        if (weights !== {N{4'h8}}) $display("FAIL reset_weights got %h exp %h", weights, {N{4'h8}});
        else n_pass++;
        n_total++;
        if ({weight_up, weight_down, scan_busy} !== '0)
            $display("FAIL reset_drive got %h exp 0", {weight_up, weight_down, scan_busy});
        else n_pass++;
    endtask

    task automatic test_drive();
        logic [N-1:0] p5;
        do_reset();
        p5 = '0;
        p5[5] = 1'b1;
        tick(p5, 1'b0, 1'b0);
        n_total++;
        if ({weight_up[5], weight_down[5]} !== 2'b00)
            $display("FAIL drive_mid got %b exp 00", {weight_up[5], weight_down[5]});
        else n_pass++;
        // Potentiate syn 5 to 9.
        idle(20, 1'b1);
        tick(p5, 1'b0, 1'b1);
        idle(4, 1'b1);
        tick('0, 1'b1, 1'b1);
        idle(40, 1'b1);
        n_total++;
        if (weights[5*WB +: WB] !== 4'd9) $display("FAIL drive_w5 got %0d exp 9", weights[5*WB +: WB]);
        else n_pass++;
        tick(p5, 1'b0, 1'b0);
        n_total++;
        if ({weight_up[5], weight_down} !== {1'b1, {N{1'b0}}})
            $display("FAIL drive_up got %b/%h exp 1/0", weight_up[5], weight_down);
        else n_pass++;
        tick('0, 1'b0, 1'b0);
        n_total++;
        if (weight_up !== '0) $display("FAIL drive_up_len got %h exp 0", weight_up);
        else n_pass++;
    endtask

    task automatic test_potentiation();
        logic [N-1:0] p3;
        logic [N*WB-1:0] expw;
        int busy_cnt;
        do_reset();
        p3 = '0;
        p3[3] = 1'b1;
        busy_cnt = 0;
        tick(p3, 1'b0, 1'b1);
        idle(4, 1'b1);
        tick('0, 1'b1, 1'b1);
        busy_cnt += int'(scan_busy);
        tick('0, 1'b1, 1'b1);
        busy_cnt += int'(scan_busy);
        for (int k = 0; k < 40; k++) begin
            tick('0, 1'b0, 1'b1);
            busy_cnt += int'(scan_busy);
        end
        n_total++;
        if (busy_cnt !== 25) $display("FAIL pot_busy_cycles got %0d exp 25", busy_cnt);
        else n_pass++;
        expw = {N{4'h8}};
        expw[3*WB +: WB] = 4'd9;
        n_total++;
        if (weights !== expw) $display("FAIL pot_weights got %h exp %h", weights, expw);
        else n_pass++;
        n_total++;
        if (weights !== model_weights())
            $display("FAIL pot_model got %h exp %h", weights, model_weights());
        else n_pass++;
    endtask

    task automatic test_depression();
        logic [N-1:0] p7;
        do_reset();
        p7 = '0;
        p7[7] = 1'b1;
        tick('0, 1'b1, 1'b1);
        idle(3, 1'b1);
        tick(p7, 1'b0, 1'b1);
        n_total++;
        if (weights[7*WB +: WB] !== 4'd7) $display("FAIL dep_w7 got %0d exp 7", weights[7*WB +: WB]);
        else n_pass++;
        idle(15, 1'b1);
        tick(p7, 1'b0, 1'b1);
        n_total++;
        if (weights[7*WB +: WB] !== 4'd7)
            $display("FAIL dep_expired got %0d exp 7", weights[7*WB +: WB]);
        else n_pass++;
        idle(20, 1'b1);
    endtask

    task automatic test_saturation();
        logic [N-1:0] p;
        logic [N*WB-1:0] snap;
        int busy_seen;
        do_reset();
        for (int r = 0; r < 10; r++) begin
            p = '0;
            p[0] = 1'b1;
            tick(p, 1'b0, 1'b1);
            idle(2, 1'b1);
            tick('0, 1'b1, 1'b1);
            idle(35, 1'b1);
        end
        n_total++;
        if (weights[0 +: WB] !== 4'd15) $display("FAIL sat_high got %0d exp 15", weights[0 +: WB]);
        else n_pass++;
        for (int r = 0; r < 10; r++) begin
            p = '0;
            p[1] = 1'b1;
            tick('0, 1'b1, 1'b1);
            idle(2, 1'b1);
            tick(p, 1'b0, 1'b1);
            idle(35, 1'b1);
        end
        n_total++;
        if (weights[WB +: WB] !== 4'd0) $display("FAIL sat_low got %0d exp 0", weights[WB +: WB]);
        else n_pass++;
        // Same stimulus on syn 2 with learning off.
        snap = model_weights();
        busy_seen = 0;
        p = '0;
        p[2] = 1'b1;
        tick(p, 1'b0, 1'b0);
        idle(2, 1'b0);
        tick('0, 1'b1, 1'b0);
        busy_seen += int'(scan_busy);
        idle(2, 1'b0);
        tick(p, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            tick('0, 1'b0, 1'b0);
            busy_seen += int'(scan_busy);
        end
        n_total++;
        if (busy_seen !== 0) $display("FAIL gate_busy got %0d exp 0", busy_seen);
        else n_pass++;
        n_total++;
        if (weights !== snap) $display("FAIL gate_weights got %h exp %h", weights, snap);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [N*WB-1:0] expw;
        do_reset();
        tick('1, 1'b0, 1'b1);
        tick('0, 1'b0, 1'b1);
        tick('0, 1'b1, 1'b1);
        idle(10, 1'b1);
        n_total++;
        if (scan_busy !== 1'b1) $display("FAIL abort_busy_pre got %b exp 1", scan_busy);
        else n_pass++;
        tick('0, 1'b0, 1'b0);
        n_total++;
        if (scan_busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", scan_busy);
        else n_pass++;
        idle(30, 1'b1);
        expw = {N{4'h8}};
        for (int i = 0; i < 10; i++) expw[i*WB +: WB] = 4'd9;
        n_total++;
        if (weights !== expw) $display("FAIL abort_weights got %h exp %h", weights, expw);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [N-1:0] p;
        do_reset();
        p = '0;
        p[12] = 1'b1;
        p[13] = 1'b1;
        tick(p, 1'b0, 1'b1);
        tick('0, 1'b0, 1'b1);
        tick('0, 1'b1, 1'b1);
        idle(12, 1'b1);
        p = '0;
        p[12] = 1'b1;
        tick(p, 1'b0, 1'b1);
        idle(20, 1'b1);
        n_total++;
        if (weights[12*WB +: WB] !== 4'd8)
            $display("FAIL collide_w12 got %0d exp 8", weights[12*WB +: WB]);
        else n_pass++;
        n_total++;
        if (weights[13*WB +: WB] !== 4'd9)
            $display("FAIL collide_w13 got %0d exp 9", weights[13*WB +: WB]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] p;
        logic l;
        int post_left;
        int bad;
        do_reset();
        post_left = 0;
        l = 1'b1;
        bad = 0;
        for (int k = 0; k < 1500; k++) begin
            p = '0;
            for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 19) == 0);
            if (post_left == 0 && $urandom_range(0, 24) == 0) post_left = $urandom_range(1, 2) + 1;
            if ($urandom_range(0, 59) == 0) l = ~l;
            tick(p, post_left > 1, l);
            if (post_left > 0) post_left--;
            n_total++;
            if (weights !== model_weights() || weight_up !== exp_up || weight_down !== exp_down
                || scan_busy !== scanning) begin
                if (bad < 5)
                    $display("FAIL random_cyc%0d got w=%h u=%h d=%h b=%b exp w=%h u=%h d=%h b=%b",
                             k, weights, weight_up, weight_down, scan_busy, model_weights(),
                             exp_up, exp_down, scanning);
                bad++;
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        tick('1, 1'b0, 1'b1);
        tick('0, 1'b1, 1'b1);
        idle(8, 1'b1);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (weights !== {N{4'h8}}) $display("FAIL midreset_weights got %h exp %h", weights, {N{4'h8}});
        else n_pass++;
        n_total++;
        if ({weight_up, weight_down, scan_busy} !== '0)
            $display("FAIL midreset_outs got %h exp 0", {weight_up, weight_down, scan_busy});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_drive();
        test_potentiation();
        test_depression();
        test_saturation();
        test_abort();
        test_collision();
        test_random();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stdp_synapse_array.md
Name: stdp_synapse_array

Overview:
Input-side synapse layer that drives the output neuron's weight_up/weight_down buses and consumes its post pulse. It holds one weight per synapse for 25 pre-synaptic spike lines (5x5 pixel patch). It presents each pre-spike as excitatory or inhibitory drive. While learn is high, it applies pair-based STDP: potentiation through a sequential scan triggered by post, and depression in parallel on late pre-spikes.

Parameters:
N_SYN, 25, number of synapses (bus width)
W_BITS, 4, weight width; weight range 0..2^W_BITS-1
W_INIT, 8, reset value of every weight
W_MID, 8, neutral weight: above drives up, below drives down
WIN, 15, STDP window length in clk cycles (trace load value)
T_BITS, 4, trace counter width (must hold WIN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
learn  in  1  learning enable; high = STDP active
pre_spike  in  N_SYN  per-synapse pre-synaptic spike, 1-cycle pulses
post  in  1  post-synaptic pulse from output neuron (level, may be 1-2 cycles wide)
weight_up  out  N_SYN  registered excitatory drive per synapse
weight_down  out  N_SYN  registered inhibitory drive per synapse
weights  out  N_SYN*W_BITS  flattened weight array, synapse i at [i*W_BITS +: W_BITS]
scan_busy  out  1  high while the potentiation scan is running

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. All weights = W_INIT. All traces = 0. weight_up = weight_down = 0. scan_busy = 0. FSM = IDLE. post_d = 0.
- Drive, 1-cycle latency: weight_up[i] <= pre_spike[i] && w[i] > W_MID; weight_down[i] <= pre_spike[i] && w[i] < W_MID; w[i] == W_MID drives neither. Uses the pre-update weight of that cycle. Independent of learn.
- Pre trace, per synapse: pre_spike[i] loads WIN. Otherwise it decrements by 1 per cycle, saturating at 0. Traces run regardless of learn.
- Post trace: post_rise = post && !post_d. post_rise loads WIN; otherwise decrements, saturating at 0. A multi-cycle post counts as one event.
- Potentiation FSM, states IDLE and SCAN:
  - IDLE->SCAN when post_rise && learn. Idx = 0. Pre traces are snapshotted into a pend[N_SYN] mask (trace > 0) in the same cycle.
  - In SCAN, per cycle: if pend[idx], then w[idx] = min(w[idx]+1, max). idx++.
  - SCAN->IDLE after idx == N_SYN-1 is processed. A full scan takes N_SYN cycles.
  - scan_busy = (state == SCAN), registered.
  - post_rise while in SCAN is ignored for scanning; the post trace still reloads.
  - learn falling while in SCAN aborts the scan: next state IDLE. Weights already updated are kept; unprocessed indices are dropped.
- Depression, parallel: if learn && pre_spike[i] && post_trace > 0, then w[i] = max(w[i]-1, 0) in that cycle.
- Collision rule: if the scanner increments idx == i and depression hits i in the same cycle, w[i] is unchanged (net zero).
- pre_spike[i] in the same cycle as post_rise: the snapshot takes the pre-update trace. pre_trace counts only if it was already > 0, so no self-pairing. Depression in that cycle uses the old post_trace.
- Saturation: weights never wrap. Increment at 2^W_BITS-1 holds; decrement at 0 holds.
- Mid-operation reset: everything returns to reset values immediately, asynchronously.

Decomposition:
- Package snn_syn_pkg holds:
  - N_SYN, W_BITS, W_MID, WIN, T_BITS defaults
  - weight_t typedef (W_BITS unsigned)
  - the scan state enum {IDLE, SCAN}
- Natural sub-module: syn_trace, a loadable saturating down-counter. It is instantiated N_SYN times for pre traces and once for the post trace.

Test Plan:
- Reset: assert rst_n=0 mid-scan -> weights all 8, weight_up/down = 0, scan_busy = 0 immediately.
- Drive: weight[5]=8, pulse pre_spike[5] -> no up/down. After potentiating w[5] to 9, pulse pre_spike[5] -> weight_up[5]=1 exactly one cycle later, weight_down=0.
- Potentiation: learn=1, pre_spike[3] at t, post rising at t+5 -> scan_busy high for 25 cycles. w[3] 8->9; all others stay 8. post held 2 cycles -> only one scan.
- Depression: learn=1, post rising at t, pre_spike[7] at t+4 -> w[7] 8->7 one cycle later. pre_spike[7] at t+20 (trace expired) -> no change.
- Saturation and learn gating:
  - Repeat potentiation on syn 0 ten times -> w[0] stops at 15.
  - Repeat depression on syn 1 ten times -> w[1] stops at 0.
  - With learn=0, the same stimulus -> no weight change and scan_busy stays 0.
- Abort and collision:
  - Drop learn 10 cycles into a scan -> FSM returns to IDLE; indices >= 10 are not updated.
  - Depression on idx i in the same cycle the scanner increments i -> w[i] unchanged.
